// File: rtl/mon_sopc_ram_loader.sv
// Byte-stream loader for the SOPC RAM: packs bytes little-endian into 32-bit words, writes them
// from a base word address, then optionally reads the region back and checks the additive sum.
module mon_sopc_ram_loader #(
  parameter int DEPTH  = 5120,
  parameter int ADDR_W = 13,
  parameter bit VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [14:0]       byte_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_verify,
  output logic [31:0]       checksum
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_VERIFY, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, base_q, base_d, address_q, address_d;
  logic [14:0]       left_q, left_d;
  logic [15:0]       nwords_q, nwords_d, vleft_q, vleft_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       pack_q, pack_d, vsum_q, vsum_d, wdata_q, wdata_d, sum_q, sum_d;
  logic [3:0]        last_be_q, last_be_d, be_q, be_d;
  logic              rd_pend_q, rd_pend_d, rd_last_q, rd_last_d;
  logic              s_ready_q, s_ready_d, cs_q, cs_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic              err_range_q, err_range_d, err_verify_q, err_verify_d;

  logic [15:0] nwords;
  logic        out_of_range;
  logic [3:0]  cnt_be, fill_be;
  logic [31:0] pack_new, rmask, vsum_next;

  assign nwords       = ({1'b0, byte_count} + 16'd3) >> 2;
  assign out_of_range = (16'(base_addr) + nwords) > 16'(DEPTH);
  assign cnt_be       = (byte_count[1:0] == 2'd0) ? 4'hF : 4'((5'd1 << byte_count[1:0]) - 5'd1);
  assign fill_be      = 4'((5'd2 << lane_q) - 5'd1);
  assign pack_new     = pack_q | (32'(s_data) << {lane_q, 3'b000});
  // Only the final word of the region can carry lanes that were never written.
  assign rmask        = rd_last_q ? {{8{last_be_q[3]}}, {8{last_be_q[2]}}, {8{last_be_q[1]}}, {8{last_be_q[0]}}}
                                  : 32'hFFFF_FFFF;
  assign vsum_next    = vsum_q + (readdata & rmask);

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    base_d       = base_q;
    address_d    = address_q;
    left_d       = left_q;
    nwords_d     = nwords_q;
    vleft_d      = vleft_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    vsum_d       = vsum_q;
    wdata_d      = wdata_q;
    sum_d        = sum_q;
    last_be_d    = last_be_q;
    be_d         = be_q;
    rd_pend_d    = rd_pend_q;
    rd_last_d    = rd_last_q;
    s_ready_d    = s_ready_q;
    cs_d         = cs_q;
    wr_d         = wr_q;
    done_d       = 1'b0;
    err_range_d  = err_range_q;
    err_verify_d = err_verify_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        err_range_d  = 1'b0;
        err_verify_d = 1'b0;
        sum_d        = '0;
        base_d       = base_addr;
        waddr_d      = base_addr;
        left_d       = byte_count;
        nwords_d     = nwords;
        last_be_d    = cnt_be;
        lane_d       = '0;
        pack_d       = '0;
        if (byte_count == 15'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (out_of_range) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          err_range_d = 1'b1;
        end else begin
          state_d   = S_FILL;
          s_ready_d = 1'b1;
        end
      end
      S_FILL: if (s_valid && s_ready_q) begin
        left_d = left_q - 15'd1;
        if (lane_q == 2'd3 || left_q == 15'd1) begin
          state_d   = S_WRITE;
          s_ready_d = 1'b0;
          cs_d      = 1'b1;
          wr_d      = 1'b1;
          address_d = waddr_q;
          wdata_d   = pack_new;
          be_d      = fill_be;
          pack_d    = '0;
          lane_d    = '0;
        end else begin
          pack_d = pack_new;
          lane_d = lane_q + 2'd1;
        end
      end
      S_WRITE: begin
        sum_d   = sum_q + wdata_q;
        waddr_d = waddr_q + ADDR_W'(1);
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        be_d    = 4'h0;
        if (left_q != 15'd0) begin
          state_d   = S_FILL;
          s_ready_d = 1'b1;
        end else if (VERIFY) begin
          state_d   = S_VERIFY;
          cs_d      = 1'b1;
          be_d      = 4'hF;
          address_d = base_q;
          vleft_d   = nwords_q - 16'd1;
          vsum_d    = '0;
          rd_pend_d = 1'b0;
          rd_last_d = 1'b0;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_VERIFY: begin
        // Data for the address issued last cycle arrives now; the first cycle has none pending.
        if (rd_pend_q) vsum_d = vsum_next;
        rd_pend_d = 1'b1;
        if (vleft_q == 16'd0) begin
          state_d   = S_DRAIN;
          cs_d      = 1'b0;
          be_d      = 4'h0;
          rd_last_d = 1'b1;
        end else begin
          address_d = address_q + ADDR_W'(1);
          vleft_d   = vleft_q - 16'd1;
        end
      end
      S_DRAIN: begin
        err_verify_d = (vsum_next != sum_q);
        vsum_d       = vsum_next;
        rd_pend_d    = 1'b0;
        rd_last_d    = 1'b0;
        state_d      = S_DONE;
        done_d       = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      waddr_q      <= '0;
      base_q       <= '0;
      address_q    <= '0;
      left_q       <= '0;
      nwords_q     <= '0;
      vleft_q      <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      vsum_q       <= '0;
      wdata_q      <= '0;
      sum_q        <= '0;
      last_be_q    <= '0;
      be_q         <= '0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      s_ready_q    <= 1'b0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_range_q  <= 1'b0;
      err_verify_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      base_q       <= base_d;
      address_q    <= address_d;
      left_q       <= left_d;
      nwords_q     <= nwords_d;
      vleft_q      <= vleft_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      vsum_q       <= vsum_d;
      wdata_q      <= wdata_d;
      sum_q        <= sum_d;
      last_be_q    <= last_be_d;
      be_q         <= be_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      s_ready_q    <= s_ready_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_range_q  <= err_range_d;
      err_verify_q <= err_verify_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign address    = address_q;
  assign byteenable = be_q;
  assign chipselect = cs_q;
  assign write      = wr_q;
  assign writedata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_range  = err_range_q;
  assign err_verify = err_verify_q;
  assign checksum   = sum_q;
endmodule

// File: tb/tb_mon_sopc_ram_loader.sv
// Directed bench for mon_sopc_ram_loader: a RAM model with 1-cycle reads, a word-level model of the
// expected writes/checksum/flags, a per-cycle compare process and literal checks per case.
module tb_mon_sopc_ram_loader;
  localparam int DEPTH = 5120;
  typedef struct packed { logic [12:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [12:0] base_addr = '0;
  logic [14:0] byte_count = '0;
  logic [7:0]  s_data = '0;
  logic        s_ready, chipselect, write, busy, done, err_range, err_verify;
  logic [12:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata, readdata, checksum;

  int checks = 0, failures = 0;
  wr_t         exp_wq[$];
  wr_t         wr_log[$];
  logic [31:0] exp_sum = '0;
  logic        exp_rng = 1'b0, exp_ver = 1'b0;
  logic [12:0] exp_base = '0;
  int          exp_nreads = 0, vidx = 0, cs_cnt = 0, last_lat = 0;
  bit          cmp_en = 1'b0;
  logic        prev_done = 1'b0;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rd_q = '0;
  bit          init_mem = 1'b1, corrupt_en = 1'b0;
  logic [12:0] corrupt_addr = 13'd1;

  mon_sopc_ram_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .byte_count(byte_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .write(write), .writedata(writedata),
    .readdata(readdata), .busy(busy), .done(done), .err_range(err_range),
    .err_verify(err_verify), .checksum(checksum)
  );

  initial forever #5 clk = ~clk;

  // RAM model: byte-lane writes, registered read; unwritten words hold recognisable garbage.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (chipselect && write) begin
      for (int l = 0; l < 4; l++) if (byteenable[l]) mem[address][8*l +: 8] <= writedata[8*l +: 8];
    end
    rd_q <= mem[address] ^ ((corrupt_en && address == corrupt_addr) ? 32'h0000_0100 : 32'h0);
  end
  assign readdata = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      wr_t e;
      chk("done_pulse", 32'(done & prev_done), 32'd0);
      if (!busy) chk("idle_bus", {25'd0, chipselect, write, s_ready, byteenable}, 32'd0);
      if (s_ready) chk("fill_bus", {26'd0, chipselect, write, byteenable}, 32'd0);
      if (chipselect) cs_cnt++;
      if (chipselect && write) begin
        wr_log.push_back('{address, writedata, byteenable});
        if (exp_wq.size() == 0) chk("unexpected_write", 32'(address), 32'hFFFF_FFFF);
        else begin
          e = exp_wq.pop_front();
          chk("wr_addr", 32'(address), 32'(e.addr));
          chk("wr_data", writedata, e.data);
          chk("wr_be", 32'(byteenable), 32'(e.be));
        end
      end
      if (chipselect && !write) begin
        chk("vrf_addr", 32'(address), 32'(exp_base + 13'(vidx)));
        vidx++;
      end
      if (done) begin
        chk("done_checksum", checksum, exp_sum);
        chk("done_err_range", 32'(err_range), 32'(exp_rng));
        chk("done_err_verify", 32'(err_verify), 32'(exp_ver));
        chk("pending_writes", 32'(exp_wq.size()), 32'd0);
        chk("vrf_reads", 32'(vidx), 32'(exp_nreads));
      end
    end
    prev_done = done;
  end

  task automatic run_op(input logic [12:0] base, input logic [14:0] cnt, input logic [7:0] first,
                        input bit gaps, input bit corrupt);
    int nw, k, guard, lat;
    bit inr;
    logic [31:0] d;
    logic [3:0] be;
    nw  = (int'(cnt) + 3) / 4;
    inr = (cnt != 15'd0) && (int'(base) + nw <= DEPTH);
    exp_wq.delete();
    wr_log.delete();
    exp_sum    = '0;
    vidx       = 0;
    cs_cnt     = 0;
    exp_rng    = (cnt != 15'd0) && !inr;
    exp_ver    = inr && corrupt;
    exp_base   = base;
    exp_nreads = inr ? nw : 0;
    corrupt_en = corrupt;
    if (inr) for (int w = 0; w < nw; w++) begin
      d  = '0;
      be = '0;
      for (int l = 0; l < 4; l++) if (4*w + l < int'(cnt)) begin
        d[8*l +: 8] = first + 8'(4*w + l);
        be[l] = 1'b1;
      end
      exp_wq.push_back('{base + 13'(w), d, be});
      exp_sum += d;
    end
    cmp_en = 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = base; byte_count = cnt;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    guard = 0;
    while (inr && k < int'(cnt) && guard < 2000) begin
      if (gaps && guard % 4 == 2) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_data  = first + 8'(k);
      end
      if (s_valid && s_ready) k++;
      guard++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 32'(done), 32'd1);
    last_lat = lat;
    @(negedge clk);
    corrupt_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'(|{s_ready, address, byteenable, chipselect, write, writedata, busy,
                            done, err_range, err_verify, checksum}), 32'd0);
    init_mem = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);

    run_op(13'd0, 15'd8, 8'h01, 1'b1, 1'b0);
    chk("c1_checksum", checksum, 32'h0C0A_0806);
    chk("c1_nwrites", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      chk("c1_w0", wr_log[0].data, 32'h0403_0201);
      chk("c1_w1", wr_log[1].data, 32'h0807_0605);
      chk("c1_be1", 32'(wr_log[1].be), 32'hF);
    end
    chk("c1_errs", 32'({err_range, err_verify}), 32'd0);

    run_op(13'd10, 15'd6, 8'hAA, 1'b0, 1'b0);
    chk("c2_nwrites", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      chk("c2_w0", wr_log[0].data, 32'hADAC_ABAA);
      chk("c2_a1", 32'(wr_log[1].addr), 32'd11);
      chk("c2_w1", wr_log[1].data, 32'h0000_AFAE);
      chk("c2_be1", 32'(wr_log[1].be), 32'h3);
    end
    chk("c2_err_verify", 32'(err_verify), 32'd0);

    run_op(13'd5118, 15'd12, 8'h10, 1'b0, 1'b0);
    chk("c3_err_range", 32'(err_range), 32'd1);
    chk("c3_cs_cycles", 32'(cs_cnt), 32'd0);

    run_op(13'd0, 15'd0, 8'h00, 1'b0, 1'b0);
    chk("c4_latency", 32'(last_lat), 32'd1);
    chk("c4_checksum", checksum, 32'd0);
    chk("c4_cs_cycles", 32'(cs_cnt), 32'd0);

    run_op(13'd0, 15'd8, 8'h01, 1'b0, 1'b1);
    chk("c5_err_verify", 32'(err_verify), 32'd1);

    run_op(13'd5119, 15'd4, 8'h40, 1'b0, 1'b0);
    chk("edge_ok_range", 32'(err_range), 32'd0);
    chk("edge_ok_sum", checksum, 32'h4342_4140);
    run_op(13'd5119, 15'd5, 8'h40, 1'b0, 1'b0);
    chk("edge_bad_range", 32'(err_range), 32'd1);
    run_op(13'd100, 15'd13, 8'h30, 1'b1, 1'b0);
    chk("c13_nwrites", 32'(wr_log.size()), 32'd4);

    cmp_en = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 13'd0; byte_count = 15'd8;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h01;
    @(negedge clk);
    s_data = 8'h02;
    @(negedge clk);
    s_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("abort_outputs", 32'(|{s_ready, address, byteenable, chipselect, write, writedata, busy,
                              done, err_range, err_verify, checksum}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(13'd0, 15'd8, 8'h01, 1'b0, 1'b0);
    chk("restart_checksum", checksum, 32'h0C0A_0806);
    chk("restart_errs", 32'({err_range, err_verify}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
